writeback_stage: RTL and testbench



---
 rtl/writeback_stage_pkg.sv | 33 +++
 rtl/writeback_stage_gpr_lane_gen.sv | 33 +++
 rtl/writeback_stage.sv | 158 +++++++++++++++
 tb/tb_writeback_stage.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/writeback_stage_pkg.sv
// Shared encodings and the latched-result record for the writeback stage.
package writeback_stage_pkg;

    localparam logic [1:0] WB_EMPTY  = 2'b00;
    localparam logic [1:0] WB_FULL   = 2'b01;
    localparam logic [1:0] WB_XMM_HI = 2'b10;

    localparam logic [1:0] OPSZ_8  = 2'b00;
    localparam logic [1:0] OPSZ_16 = 2'b01;
    localparam logic [1:0] OPSZ_32 = 2'b10;

    localparam logic [1:0] BYP_NONE = 2'b00;
    localparam logic [1:0] BYP_D1   = 2'b01;
    localparam logic [1:0] BYP_D2   = 2'b10;

    typedef struct packed {
        logic [2:0]  dr1;
        logic [2:0]  dr2;
        logic [2:0]  dr_seg;
        logic        dr1_wen;
        logic        dr2_wen;
        logic        seg_wen;
        logic        xmm;
        logic [1:0]  op_size;
        logic [31:0] res1;
        logic [31:0] res2;
        logic [63:0] xres;
        logic [5:0]  flags;
        logic [5:0]  flags_mod;
        logic        lastuop;
    } wb_result_t;

endpackage

// File: rtl/writeback_stage_gpr_lane_gen.sv
// Maps a GPR destination id and operand size onto a register-file address,
// byte enables and lane-aligned write data.
module gpr_lane_gen #(
    parameter int DW = 32
) (
    input  logic [2:0]    id,
    input  logic [1:0]    op_size,
    input  logic [DW-1:0] data,
    output logic [2:0]    addr,
    output logic [3:0]    be,
    output logic [DW-1:0] wd
);
    import writeback_stage_pkg::*;

    // 8-bit ids 4-7 name the high byte (AH..BH) of registers 0-3
    always_comb begin
        addr = id;
        be   = 4'b1111;
        wd   = data;
        if (op_size == OPSZ_16) begin
            be = 4'b0011;
        end else if (op_size == OPSZ_8) begin
            if (id[2]) begin
                addr = {1'b0, id[1:0]};
                be   = 4'b0010;
                wd   = {data[DW-1:16], data[7:0], data[7:0]};
            end else begin
                be = 4'b0001;
            end
        end
    end

endmodule

// File: rtl/writeback_stage.sv
// Final pipeline stage: latches execute results, writes GPR/XMM/segment files
// and EFLAGS, drives the writeback bypass and counts retired instructions.
module writeback_stage
    import writeback_stage_pkg::*;
#(
    parameter int DW     = 32,
    parameter int RCNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_v,
    input  logic              i_inv,
    output logic              o_ready,
    input  logic [2:0]        i_dr1,
    input  logic [2:0]        i_dr2,
    input  logic [2:0]        i_drSeg,
    input  logic              i_dr1Wen,
    input  logic              i_dr2Wen,
    input  logic              i_segWen,
    input  logic              i_xmm,
    input  logic [1:0]        i_opSize,
    input  logic [DW-1:0]     i_res1,
    input  logic [DW-1:0]     i_res2,
    input  logic [63:0]       i_xres,
    input  logic [5:0]        i_flags,
    input  logic [5:0]        i_flags_mod,
    input  logic              i_lastuop,
    output logic              gpr_we1,
    output logic              gpr_we2,
    output logic [2:0]        gpr_wa1,
    output logic [2:0]        gpr_wa2,
    output logic [3:0]        gpr_be1,
    output logic [3:0]        gpr_be2,
    output logic [DW-1:0]     gpr_wd1,
    output logic [DW-1:0]     gpr_wd2,
    output logic              xmm_we,
    output logic [2:0]        xmm_wa,
    output logic              xmm_hi,
    output logic [31:0]       xmm_wd,
    output logic              seg_we,
    output logic [2:0]        seg_wa,
    output logic [15:0]       seg_wd,
    output logic [5:0]        flags_q,
    output logic [2:0]        wb_s1,
    output logic [2:0]        wb_s2,
    output logic [2:0]        wb_seg,
    output logic [1:0]        wbwe_s1,
    output logic [1:0]        wbwe_s2,
    output logic [1:0]        wbwe_seg,
    output logic              wbxmm,
    output logic              wbv,
    output logic [DW-1:0]     wb_data1,
    output logic [DW-1:0]     wb_data2,
    output logic [RCNT_W-1:0] retired
);

    logic [1:0] state;
    wb_result_t lat;
    logic       xmm2;
    logic       accept;
    logic       full_v;
    logic       hi_v;
    logic       last_cycle;
    logic       same_dst;

    assign xmm2       = lat.xmm & lat.dr2_wen;
    assign o_ready    = (state != WB_XMM_HI) && ((state != WB_FULL) || !xmm2);
    assign accept     = i_v & o_ready & ~i_inv;
    assign full_v     = (state == WB_FULL) & ~i_inv;
    assign hi_v       = (state == WB_XMM_HI) & ~i_inv;
    assign last_cycle = (full_v & ~xmm2) | hi_v;
    assign same_dst   = lat.dr1_wen & lat.dr2_wen & (lat.dr1 == lat.dr2) & ~lat.xmm;

    // A flush wins over everything; a split XMM result always takes its upper-half cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= WB_EMPTY;
            lat     <= '0;
            flags_q <= '0;
            retired <= '0;
        end else begin
            if (i_inv)
                state <= WB_EMPTY;
            else if (accept)
                state <= WB_FULL;
            else if ((state == WB_FULL) && xmm2)
                state <= WB_XMM_HI;
            else
                state <= WB_EMPTY;

            if (accept) begin
                lat.dr1       <= i_dr1;
                lat.dr2       <= i_dr2;
                lat.dr_seg    <= i_drSeg;
                lat.dr1_wen   <= i_dr1Wen;
                lat.dr2_wen   <= i_dr2Wen;
                lat.seg_wen   <= i_segWen;
                lat.xmm       <= i_xmm;
                lat.op_size   <= i_opSize;
                lat.res1      <= i_res1;
                lat.res2      <= i_res2;
                lat.xres      <= i_xres;
                lat.flags     <= i_flags;
                lat.flags_mod <= i_flags_mod;
                lat.lastuop   <= i_lastuop;
            end

            if (full_v)
                flags_q <= (flags_q & ~lat.flags_mod) | (lat.flags & lat.flags_mod);

            if (last_cycle && lat.lastuop)
                retired <= retired + {{(RCNT_W-1){1'b0}}, 1'b1};
        end
    end

    gpr_lane_gen #(.DW(DW)) u_lane1 (
        .id      (lat.dr1),
        .op_size (lat.op_size),
        .data    (lat.res1),
        .addr    (gpr_wa1),
        .be      (gpr_be1),
        .wd      (gpr_wd1)
    );

    gpr_lane_gen #(.DW(DW)) u_lane2 (
        .id      (lat.dr2),
        .op_size (lat.op_size),
        .data    (lat.res2),
        .addr    (gpr_wa2),
        .be      (gpr_be2),
        .wd      (gpr_wd2)
    );

    assign gpr_we1 = full_v & lat.dr1_wen & ~same_dst;
    assign gpr_we2 = full_v & lat.dr2_wen & ~lat.xmm;

    assign xmm_we = (full_v | hi_v) & xmm2;
    assign xmm_wa = lat.dr2;
    assign xmm_hi = (state == WB_XMM_HI);
    assign xmm_wd = xmm_hi ? lat.xres[63:32] : lat.xres[31:0];

    // Segment data borrows whichever bypass bus dr1 leaves free
    assign seg_we = full_v & lat.seg_wen;
    assign seg_wa = lat.dr_seg;
    assign seg_wd = lat.dr1_wen ? lat.res2[15:0] : lat.res1[15:0];

    assign wb_s1    = lat.dr1;
    assign wb_s2    = lat.dr2;
    assign wb_seg   = lat.dr_seg;
    assign wbwe_s1  = (full_v & lat.dr1_wen) ? BYP_D1 : BYP_NONE;
    assign wbwe_s2  = ((full_v | hi_v) & lat.dr2_wen) ? BYP_D2 : BYP_NONE;
    assign wbwe_seg = (full_v & lat.seg_wen) ? (lat.dr1_wen ? BYP_D2 : BYP_D1) : BYP_NONE;
    assign wbxmm    = (full_v | hi_v) & lat.xmm;
    assign wbv      = full_v | hi_v;
    assign wb_data1 = lat.res1;
    assign wb_data2 = lat.xmm ? xmm_wd : lat.res2;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed self-checking bench for writeback_stage: vector table plus
// hand-written XMM, flush and asynchronous-reset sequences.
module tb_writeback_stage;
    import writeback_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_v, i_inv, o_ready;
    logic [2:0]  i_dr1, i_dr2, i_drSeg;
    logic        i_dr1Wen, i_dr2Wen, i_segWen, i_xmm, i_lastuop;
    logic [1:0]  i_opSize;
    logic [31:0] i_res1, i_res2;
    logic [63:0] i_xres;
    logic [5:0]  i_flags, i_flags_mod;
    logic        gpr_we1, gpr_we2, xmm_we, xmm_hi, seg_we, wbxmm, wbv;
    logic [2:0]  gpr_wa1, gpr_wa2, xmm_wa, seg_wa, wb_s1, wb_s2, wb_seg;
    logic [3:0]  gpr_be1, gpr_be2;
    logic [31:0] gpr_wd1, gpr_wd2, xmm_wd, wb_data1, wb_data2, retired;
    logic [15:0] seg_wd;
    logic [5:0]  flags_q;
    logic [1:0]  wbwe_s1, wbwe_s2, wbwe_seg;

    int checks = 0;
    int failures = 0;

    writeback_stage #(.DW(32), .RCNT_W(32)) dut (
        .clk(clk), .rst(rst), .i_v(i_v), .i_inv(i_inv), .o_ready(o_ready),
        .i_dr1(i_dr1), .i_dr2(i_dr2), .i_drSeg(i_drSeg),
        .i_dr1Wen(i_dr1Wen), .i_dr2Wen(i_dr2Wen), .i_segWen(i_segWen),
        .i_xmm(i_xmm), .i_opSize(i_opSize), .i_res1(i_res1), .i_res2(i_res2),
        .i_xres(i_xres), .i_flags(i_flags), .i_flags_mod(i_flags_mod),
        .i_lastuop(i_lastuop),
        .gpr_we1(gpr_we1), .gpr_we2(gpr_we2), .gpr_wa1(gpr_wa1), .gpr_wa2(gpr_wa2),
        .gpr_be1(gpr_be1), .gpr_be2(gpr_be2), .gpr_wd1(gpr_wd1), .gpr_wd2(gpr_wd2),
        .xmm_we(xmm_we), .xmm_wa(xmm_wa), .xmm_hi(xmm_hi), .xmm_wd(xmm_wd),
        .seg_we(seg_we), .seg_wa(seg_wa), .seg_wd(seg_wd), .flags_q(flags_q),
        .wb_s1(wb_s1), .wb_s2(wb_s2), .wb_seg(wb_seg),
        .wbwe_s1(wbwe_s1), .wbwe_s2(wbwe_s2), .wbwe_seg(wbwe_seg),
        .wbxmm(wbxmm), .wbv(wbv), .wb_data1(wb_data1), .wb_data2(wb_data2),
        .retired(retired)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  dr1, dr2, dr_seg;
        logic        wen1, wen2, seg_wen;
        logic [1:0]  op_size;
        logic [31:0] res1, res2;
        logic [5:0]  flags, mod;
        logic        last;
        logic        we1; logic [2:0] wa1; logic [3:0] be1; logic [31:0] wd1;
        logic        we2; logic [2:0] wa2; logic [3:0] be2; logic [31:0] wd2;
        logic        seg_we; logic [15:0] seg_wd;
        logic [1:0]  s1, s2, sg;
        logic [5:0]  flags_exp;
        logic [31:0] ret_exp;
    } vec_t;

    vec_t vecs [6];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clearInputs();
        i_v = 1'b0; i_inv = 1'b0;
        i_dr1 = '0; i_dr2 = '0; i_drSeg = '0;
        i_dr1Wen = 1'b0; i_dr2Wen = 1'b0; i_segWen = 1'b0; i_xmm = 1'b0;
        i_opSize = OPSZ_32; i_res1 = '0; i_res2 = '0; i_xres = '0;
        i_flags = '0; i_flags_mod = '0; i_lastuop = 1'b0;
    endtask

    // One-cycle handshake from EMPTY; returns 1ns into the FULL cycle
    task automatic applyStimulus(input vec_t v);
        @(negedge clk);
        clearInputs();
        i_dr1 = v.dr1; i_dr2 = v.dr2; i_drSeg = v.dr_seg;
        i_dr1Wen = v.wen1; i_dr2Wen = v.wen2; i_segWen = v.seg_wen;
        i_opSize = v.op_size; i_res1 = v.res1; i_res2 = v.res2;
        i_flags = v.flags; i_flags_mod = v.mod; i_lastuop = v.last;
        i_v = 1'b1;
        @(posedge clk); #1;
        i_v = 1'b0;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int waited;
        bit got;

        vecs[0] = '{3'd3, 3'd0, 3'd0, 1'b1, 1'b0, 1'b0, OPSZ_32, 32'hDEADBEEF, 32'h0, 6'b101010, 6'b111111, 1'b1,
                    1'b1, 3'd3, 4'b1111, 32'hDEADBEEF, 1'b0, 3'd0, 4'b1111, 32'h0, 1'b0, 16'h0,
                    BYP_D1, BYP_NONE, BYP_NONE, 6'b101010, 32'd1};
        vecs[1] = '{3'd5, 3'd2, 3'd0, 1'b1, 1'b1, 1'b0, OPSZ_8, 32'h0000007A, 32'h12345678, 6'b000101, 6'b000111, 1'b0,
                    1'b1, 3'd1, 4'b0010, 32'h00007A7A, 1'b1, 3'd2, 4'b0001, 32'h12345678, 1'b0, 16'h0,
                    BYP_D1, BYP_D2, BYP_NONE, 6'b101101, 32'd1};
        vecs[2] = '{3'd6, 3'd7, 3'd4, 1'b1, 1'b0, 1'b1, OPSZ_16, 32'hAAAA5555, 32'hCAFE1234, 6'b111111, 6'b000000, 1'b1,
                    1'b1, 3'd6, 4'b0011, 32'hAAAA5555, 1'b0, 3'd7, 4'b0011, 32'hCAFE1234, 1'b1, 16'h1234,
                    BYP_D1, BYP_NONE, BYP_D2, 6'b101101, 32'd2};
        vecs[3] = '{3'd4, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, OPSZ_32, 32'h1, 32'h2, 6'b000000, 6'b100001, 1'b1,
                    1'b0, 3'd4, 4'b1111, 32'h1, 1'b1, 3'd4, 4'b1111, 32'h2, 1'b0, 16'h0,
                    BYP_D1, BYP_D2, BYP_NONE, 6'b001100, 32'd3};
        vecs[4] = '{3'd0, 3'd1, 3'd2, 1'b0, 1'b0, 1'b1, OPSZ_32, 32'h0000BEEF, 32'h0, 6'b010010, 6'b010010, 1'b0,
                    1'b0, 3'd0, 4'b1111, 32'h0000BEEF, 1'b0, 3'd1, 4'b1111, 32'h0, 1'b1, 16'hBEEF,
                    BYP_NONE, BYP_NONE, BYP_D1, 6'b011110, 32'd3};
        vecs[5] = '{3'd3, 3'd4, 3'd0, 1'b1, 1'b1, 1'b0, OPSZ_8, 32'h11223344, 32'h99887766, 6'b000000, 6'b000000, 1'b1,
                    1'b1, 3'd3, 4'b0001, 32'h11223344, 1'b1, 3'd0, 4'b0010, 32'h99886666, 1'b0, 16'h0,
                    BYP_D1, BYP_D2, BYP_NONE, 6'b011110, 32'd4};

        clearInputs();
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_we1", gpr_we1, 0);
        checkOutput("rst_wbv", wbv, 0);
        checkOutput("rst_wbwe", {wbwe_s1, wbwe_s2, wbwe_seg}, 0);
        checkOutput("rst_flags", flags_q, 0);
        checkOutput("rst_retired", retired, 0);
        checkOutput("rst_ready", o_ready, 1);
        checkOutput("rst_wd1", gpr_wd1, 0);
        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i]);
            checkOutput($sformatf("v%0d_we1", i), gpr_we1, vecs[i].we1);
            checkOutput($sformatf("v%0d_wa1", i), gpr_wa1, vecs[i].wa1);
            checkOutput($sformatf("v%0d_be1", i), gpr_be1, vecs[i].be1);
            checkOutput($sformatf("v%0d_wd1", i), gpr_wd1, vecs[i].wd1);
            checkOutput($sformatf("v%0d_we2", i), gpr_we2, vecs[i].we2);
            checkOutput($sformatf("v%0d_wa2", i), gpr_wa2, vecs[i].wa2);
            checkOutput($sformatf("v%0d_be2", i), gpr_be2, vecs[i].be2);
            checkOutput($sformatf("v%0d_wd2", i), gpr_wd2, vecs[i].wd2);
            checkOutput($sformatf("v%0d_seg_we", i), seg_we, vecs[i].seg_we);
            if (vecs[i].seg_we)
                checkOutput($sformatf("v%0d_seg_wd", i), seg_wd, vecs[i].seg_wd);
            checkOutput($sformatf("v%0d_wbwe_s1", i), wbwe_s1, vecs[i].s1);
            checkOutput($sformatf("v%0d_wbwe_s2", i), wbwe_s2, vecs[i].s2);
            checkOutput($sformatf("v%0d_wbwe_seg", i), wbwe_seg, vecs[i].sg);
            checkOutput($sformatf("v%0d_wb_s1", i), wb_s1, vecs[i].dr1);
            checkOutput($sformatf("v%0d_wb_data1", i), wb_data1, vecs[i].res1);
            checkOutput($sformatf("v%0d_wbv", i), wbv, 1);
            checkOutput($sformatf("v%0d_wbxmm", i), wbxmm, 0);
            @(posedge clk); #1;
            checkOutput($sformatf("v%0d_flags", i), flags_q, vecs[i].flags_exp);
            checkOutput($sformatf("v%0d_retired", i), retired, vecs[i].ret_exp);
            checkOutput($sformatf("v%0d_idle_wbv", i), wbv, 0);
        end

        // 64-bit XMM result followed by a held back-to-back GPR result
        @(negedge clk);
        clearInputs();
        i_xmm = 1'b1; i_dr2 = 3'd2; i_dr2Wen = 1'b1; i_lastuop = 1'b1;
        i_xres = 64'h11223344_55667788; i_v = 1'b1;
        @(posedge clk); #1;
        clearInputs();
        i_dr1 = 3'd1; i_dr1Wen = 1'b1; i_res1 = 32'h0BADF00D; i_lastuop = 1'b1; i_v = 1'b1;
        checkOutput("xmm_lo_we", xmm_we, 1);
        checkOutput("xmm_lo_hi", xmm_hi, 0);
        checkOutput("xmm_lo_wa", xmm_wa, 2);
        checkOutput("xmm_lo_wd", xmm_wd, 32'h55667788);
        checkOutput("xmm_lo_gpr_we2", gpr_we2, 0);
        checkOutput("xmm_lo_wbxmm", wbxmm, 1);
        checkOutput("xmm_lo_ready", o_ready, 0);
        checkOutput("xmm_lo_wb_data2", wb_data2, 32'h55667788);
        checkOutput("xmm_lo_wbwe_s2", wbwe_s2, BYP_D2);
        @(posedge clk); #1;
        checkOutput("xmm_hi_we", xmm_we, 1);
        checkOutput("xmm_hi_hi", xmm_hi, 1);
        checkOutput("xmm_hi_wd", xmm_wd, 32'h11223344);
        checkOutput("xmm_hi_gpr_we2", gpr_we2, 0);
        checkOutput("xmm_hi_wbxmm", wbxmm, 1);
        checkOutput("xmm_hi_ready", o_ready, 0);
        checkOutput("xmm_hi_wbv", wbv, 1);
        checkOutput("xmm_hi_retired", retired, 4);

        waited = 0;
        got = 1'b0;
        while (!got && waited < 8) begin
            @(negedge clk);
            if (o_ready) got = 1'b1;
            @(posedge clk); #1;
            waited++;
        end
        i_v = 1'b0;
        checkOutput("b2b_accepted", got, 1);
        checkOutput("b2b_we1", gpr_we1, 1);
        checkOutput("b2b_wa1", gpr_wa1, 1);
        checkOutput("b2b_wd1", gpr_wd1, 32'h0BADF00D);
        checkOutput("b2b_xmm_we", xmm_we, 0);
        checkOutput("b2b_retired_mid", retired, 5);
        @(posedge clk); #1;
        checkOutput("b2b_retired", retired, 6);

        // Flush during the upper-half XMM cycle, with a competing incoming result
        @(negedge clk);
        clearInputs();
        i_xmm = 1'b1; i_dr2 = 3'd5; i_dr2Wen = 1'b1; i_lastuop = 1'b1;
        i_xres = 64'hA5A5A5A5_5A5A5A5A; i_v = 1'b1;
        @(posedge clk); #1;
        i_v = 1'b0;
        checkOutput("fl_lo_we", xmm_we, 1);
        checkOutput("fl_lo_wd", xmm_wd, 32'h5A5A5A5A);
        @(posedge clk); #1;
        i_inv = 1'b1;
        i_v = 1'b1; i_xmm = 1'b0; i_dr1 = 3'd6; i_dr1Wen = 1'b1; i_dr2Wen = 1'b0;
        #1;
        checkOutput("fl_hi_xmm_we", xmm_we, 0);
        checkOutput("fl_hi_wbv", wbv, 0);
        checkOutput("fl_hi_wbwe_s2", wbwe_s2, BYP_NONE);
        @(posedge clk); #1;
        i_inv = 1'b0;
        i_v = 1'b0;
        checkOutput("fl_after_wbv", wbv, 0);
        checkOutput("fl_after_we1", gpr_we1, 0);
        checkOutput("fl_after_xmm_we", xmm_we, 0);
        checkOutput("fl_after_ready", o_ready, 1);
        checkOutput("fl_after_retired", retired, 6);

        // Flush during a FULL cycle must not touch EFLAGS or the counter
        @(negedge clk);
        clearInputs();
        i_dr1 = 3'd2; i_dr1Wen = 1'b1; i_res1 = 32'h55;
        i_flags = 6'b111111; i_flags_mod = 6'b111111; i_lastuop = 1'b1; i_v = 1'b1;
        @(posedge clk); #1;
        i_v = 1'b0;
        i_inv = 1'b1;
        #1;
        checkOutput("flf_we1", gpr_we1, 0);
        checkOutput("flf_wbv", wbv, 0);
        checkOutput("flf_wbwe_s1", wbwe_s1, BYP_NONE);
        @(posedge clk); #1;
        i_inv = 1'b0;
        checkOutput("flf_flags", flags_q, 6'b011110);
        checkOutput("flf_retired", retired, 6);
        checkOutput("flf_wbv_after", wbv, 0);

        // Asynchronous reset in the middle of a FULL cycle
        @(negedge clk);
        clearInputs();
        i_dr1 = 3'd7; i_dr1Wen = 1'b1; i_res1 = 32'h12345678;
        i_flags = 6'b111111; i_flags_mod = 6'b111111; i_lastuop = 1'b1; i_v = 1'b1;
        @(posedge clk); #1;
        i_v = 1'b0;
        checkOutput("ar_pre_we1", gpr_we1, 1);
        #2;
        rst = 1'b0;
        #1;
        checkOutput("ar_we1", gpr_we1, 0);
        checkOutput("ar_wbv", wbv, 0);
        checkOutput("ar_flags", flags_q, 0);
        checkOutput("ar_retired", retired, 0);
        checkOutput("ar_wd1", gpr_wd1, 0);
        checkOutput("ar_wa1", gpr_wa1, 0);
        checkOutput("ar_ready", o_ready, 1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        checkOutput("ar_post_wbv", wbv, 0);
        checkOutput("ar_post_retired", retired, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
